// File: rtl/md5_stream_adapter.sv
// Byte-stream front/back end for the pancham MD5 core: packs up to 16 message
// bytes into the core's 128-bit input word and streams the 16-byte digest back out.
module md5_stream_adapter (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   s_data,
  input  logic         s_valid,
  input  logic         s_last,
  output logic         s_ready,
  output logic [0:127] core_msg_in,
  output logic [0:7]   core_msg_width,
  output logic         core_msg_valid,
  input  logic         core_ready,
  input  logic [0:127] core_digest,
  input  logic         core_digest_valid,
  output logic [7:0]   d_data,
  output logic         d_valid,
  output logic         d_last,
  input  logic         d_ready,
  output logic         trunc_err
);

  typedef enum logic [2:0] {
    COLLECT,
    WAIT_CORE,
    ISSUE,
    WAIT_DIGEST,
    SEND
  } state_e;

  state_e         state_q, state_d;
  logic [0:127]   msg_q, msg_d;
  logic [4:0]     count_q, count_d;
  logic [0:127]   dig_q, dig_d;
  logic [3:0]     idx_q, idx_d;
  logic           trunc_d;

  logic           s_ready_q, msg_valid_q, d_valid_q, d_last_q, trunc_q;

  logic           s_accept, d_accept;

  assign s_accept = s_valid & s_ready_q;
  assign d_accept = d_valid_q & d_ready;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    count_d = count_q;
    dig_d   = dig_q;
    idx_d   = idx_q;
    trunc_d = 1'b0;
    case (state_q)
      COLLECT: begin
        if (s_accept) begin
          msg_d   = {msg_q[8:127], s_data};
          count_d = count_q + 5'd1;
          if (s_last || count_q == 5'd15) begin
            state_d = WAIT_CORE;
          end
          trunc_d = ~s_last && (count_q == 5'd15);
        end
      end
      WAIT_CORE: begin
        if (core_ready) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT_DIGEST;
      end
      WAIT_DIGEST: begin
        if (core_digest_valid) begin
          dig_d   = core_digest;
          idx_d   = 4'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        // The outgoing byte is always the top byte of the digest shift register.
        if (d_accept) begin
          dig_d = {dig_q[8:127], 8'h00};
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd15) begin
            state_d = COLLECT;
            msg_d   = '0;
            count_d = '0;
            idx_d   = '0;
          end
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= COLLECT;
      msg_q   <= '0;
      count_q <= '0;
      dig_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      count_q <= count_d;
      dig_q   <= dig_d;
      idx_q   <= idx_d;
    end
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_ready_q   <= 1'b0;
      msg_valid_q <= 1'b0;
      d_valid_q   <= 1'b0;
      d_last_q    <= 1'b0;
      trunc_q     <= 1'b0;
    end else begin
      s_ready_q   <= (state_d == COLLECT);
      msg_valid_q <= (state_d == ISSUE);
      d_valid_q   <= (state_d == SEND);
      d_last_q    <= (state_d == SEND) && (idx_d == 4'd15);
      trunc_q     <= trunc_d;
    end
  end

  assign s_ready        = s_ready_q;
  assign core_msg_in    = msg_q;
  assign core_msg_width = {count_q, 3'b000};
  assign core_msg_valid = msg_valid_q;
  assign d_data         = dig_q[0:7];
  assign d_valid        = d_valid_q;
  assign d_last         = d_last_q;
  assign trunc_err      = trunc_q;

endmodule

// File: tb/tb_md5_stream_adapter.sv
// Directed bench for md5_stream_adapter: the core side is driven by hand with
// known digests and every observed value is compared with hand-derived constants.
module tb_md5_stream_adapter;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   s_data = 8'h00;
  logic         s_valid = 1'b0;
  logic         s_last = 1'b0;
  logic         s_ready;
  logic [0:127] core_msg_in;
  logic [0:7]   core_msg_width;
  logic         core_msg_valid;
  logic         core_ready = 1'b0;
  logic [0:127] core_digest = '0;
  logic         core_digest_valid = 1'b0;
  logic [7:0]   d_data;
  logic         d_valid;
  logic         d_last;
  logic         d_ready = 1'b0;
  logic         trunc_err;

  int total = 0;
  int bad = 0;
  int trunc_cnt = 0;

  localparam logic [0:127] D_ABC  = 128'h900150983cd24fb0d6963f7d28e17f72;
  localparam logic [0:127] D_SEQ  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] D_X    = 128'hdeadbeef0123456789abcdeffedcba98;
  localparam logic [0:127] M_ABC  = 128'h00000000000000000000000000616263;
  localparam logic [0:127] M_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;

  logic [7:0] abc_b [16];
  logic [7:0] seq_b [16];

  md5_stream_adapter dut (
    .clk               (clk),
    .reset             (reset),
    .s_data            (s_data),
    .s_valid           (s_valid),
    .s_last            (s_last),
    .s_ready           (s_ready),
    .core_msg_in       (core_msg_in),
    .core_msg_width    (core_msg_width),
    .core_msg_valid    (core_msg_valid),
    .core_ready        (core_ready),
    .core_digest       (core_digest),
    .core_digest_valid (core_digest_valid),
    .d_data            (d_data),
    .d_valid           (d_valid),
    .d_last            (d_last),
    .d_ready           (d_ready),
    .trunc_err         (trunc_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (trunc_err) trunc_cnt++;

  task automatic drive_byte(input logic [7:0] b, input logic last);
    int guard = 0;
    @(negedge clk);
    while (!s_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      total++; bad++;
      $display("FAIL drive_timeout: s_ready=%b required 1", s_ready);
    end
    s_data = b; s_valid = 1'b1; s_last = last;
  endtask

  // Returns at the negedge just after the closing byte was accepted.
  task automatic send_msg(input logic [7:0] b [16], input int n, input bit last_final);
    for (int i = 0; i < n; i++) drive_byte(b[i], last_final && (i == n - 1));
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic observe_issue(input int window, output int first, output int pulses,
                               output logic [0:127] msg_at, output logic [7:0] w_at);
    first = 0; pulses = 0; msg_at = '0; w_at = '0;
    for (int k = 1; k <= window; k++) begin
      @(negedge clk);
      if (core_msg_valid) begin
        pulses++;
        if (first == 0) begin
          first = k; msg_at = core_msg_in; w_at = core_msg_width;
        end
      end
    end
  endtask

  task automatic give_digest(input logic [0:127] d);
    @(negedge clk);
    core_digest = d; core_digest_valid = 1'b1;
    @(negedge clk);
    core_digest_valid = 1'b0; core_digest = '0;
  endtask

  // Handshakes up to nmax digest bytes, d_ready following rdy_pat bit 0,1,2,3,...
  task automatic collect_digest(input logic [3:0] rdy_pat, input int nmax,
                                output logic [7:0] got [16], output logic [15:0] lmask,
                                output int stall_bad, output int sr_seen, output bit timeout);
    int i = 0;
    int cyc = 0;
    bit hold = 1'b0;
    logic [7:0] pdata = '0;
    logic plast = 1'b0;
    lmask = '0; stall_bad = 0; sr_seen = 0;
    for (int k = 0; k < 16; k++) got[k] = '0;
    while (i < nmax && cyc < 400) begin
      @(negedge clk);
      d_ready = rdy_pat[cyc % 4];
      cyc++;
      if (s_ready) sr_seen++;
      if (hold && (!d_valid || d_data !== pdata || d_last !== plast)) stall_bad++;
      if (d_valid && d_ready) begin
        got[i] = d_data;
        lmask[i] = d_last;
        i++;
      end
      hold = d_valid && !d_ready;
      pdata = d_data; plast = d_last;
    end
    timeout = (i < nmax);
    @(negedge clk);
    d_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({s_ready, core_msg_valid, d_valid, d_last, trunc_err, core_msg_in, core_msg_width, d_data} !== '0) begin
      bad++;
      $display("FAIL reset_values: s_ready=%b mv=%b dv=%b dl=%b te=%b msg=%h w=%h d=%h required all 0",
               s_ready, core_msg_valid, d_valid, d_last, trunc_err, core_msg_in, core_msg_width, d_data);
    end
    reset = 1'b0;
    #1;
    total++;
    if (s_ready !== 1'b0) begin bad++; $display("FAIL sready_before_edge: got %b required 0", s_ready); end
    @(negedge clk);
    total++;
    if (s_ready !== 1'b1) begin bad++; $display("FAIL sready_after_edge: got %b required 1", s_ready); end
  endtask

  task automatic test_abc();
    int first, pulses, stall, srs;
    logic [0:127] m; logic [7:0] w;
    logic [7:0] got [16]; logic [15:0] lm; bit to;
    core_ready = 1'b1;
    send_msg(abc_b, 3, 1'b1);
    total++;
    if (s_ready !== 1'b0) begin bad++; $display("FAIL abc_sready_close: got %b required 0", s_ready); end
    total++;
    if (core_msg_in !== M_ABC) begin bad++; $display("FAIL abc_msg: got %h required %h", core_msg_in, M_ABC); end
    total++;
    if (core_msg_width !== 8'h18) begin bad++; $display("FAIL abc_width: got %h required 18", core_msg_width); end
    observe_issue(4, first, pulses, m, w);
    total++;
    if (first !== 1 || pulses !== 1) begin
      bad++; $display("FAIL abc_issue: first=%0d pulses=%0d required 1 1", first, pulses);
    end
    total++;
    if (m !== M_ABC || w !== 8'h18) begin bad++; $display("FAIL abc_issue_word: got %h/%h required %h/18", m, w, M_ABC); end
    give_digest(D_ABC);
    total++;
    if (d_valid !== 1'b1 || d_data !== 8'h90) begin
      bad++; $display("FAIL abc_first_byte: dv=%b d=%h required 1 90", d_valid, d_data);
    end
    collect_digest(4'b1111, 16, got, lm, stall, srs, to);
    for (int i = 0; i < 16; i++) begin
      total++;
      if (got[i] !== D_ABC[8*i +: 8]) begin
        bad++; $display("FAIL abc_byte%0d: got %h required %h", i, got[i], D_ABC[8*i +: 8]);
      end
    end
    total++;
    if (lm !== 16'h8000 || to !== 1'b0 || srs !== 0) begin
      bad++; $display("FAIL abc_send: lastmask=%h timeout=%b sready_seen=%0d required 8000 0 0", lm, to, srs);
    end
    total++;
    if (s_ready !== 1'b1 || core_msg_in !== '0 || d_valid !== 1'b0) begin
      bad++; $display("FAIL abc_return: s_ready=%b msg=%h dv=%b required 1 0 0", s_ready, core_msg_in, d_valid);
    end
  endtask

  task automatic test_full_last();
    int first, pulses, stall, srs;
    logic [0:127] m; logic [7:0] w;
    logic [7:0] got [16]; logic [15:0] lm; bit to;
    core_ready = 1'b1;
    trunc_cnt = 0;
    send_msg(seq_b, 16, 1'b1);
    total++;
    if (core_msg_in !== M_SEQ || core_msg_width !== 8'h80) begin
      bad++; $display("FAIL full_msg: got %h/%h required %h/80", core_msg_in, core_msg_width, M_SEQ);
    end
    observe_issue(4, first, pulses, m, w);
    give_digest(D_SEQ);
    collect_digest(4'b1111, 16, got, lm, stall, srs, to);
    for (int i = 0; i < 16; i++) begin
      total++;
      if (got[i] !== D_SEQ[8*i +: 8]) begin
        bad++; $display("FAIL full_byte%0d: got %h required %h", i, got[i], D_SEQ[8*i +: 8]);
      end
    end
    total++;
    if (trunc_cnt !== 0 || first !== 1 || pulses !== 1) begin
      bad++; $display("FAIL full_trunc: trunc=%0d first=%0d pulses=%0d required 0 1 1", trunc_cnt, first, pulses);
    end
  endtask

  task automatic test_truncate();
    int first, pulses, stall, srs;
    logic [0:127] m; logic [7:0] w;
    logic [7:0] got [16]; logic [15:0] lm; bit to;
    core_ready = 1'b1;
    trunc_cnt = 0;
    send_msg(seq_b, 16, 1'b0);
    total++;
    if (core_msg_in !== M_SEQ || core_msg_width !== 8'h80 || trunc_err !== 1'b1 || s_ready !== 1'b0) begin
      bad++; $display("FAIL trunc_close: msg=%h w=%h te=%b sr=%b required %h 80 1 0",
                      core_msg_in, core_msg_width, trunc_err, s_ready, M_SEQ);
    end
    observe_issue(4, first, pulses, m, w);
    total++;
    if (trunc_err !== 1'b0 || s_ready !== 1'b0 || pulses !== 1) begin
      bad++; $display("FAIL trunc_wait: te=%b sr=%b pulses=%0d required 0 0 1", trunc_err, s_ready, pulses);
    end
    give_digest(D_X);
    collect_digest(4'b1111, 16, got, lm, stall, srs, to);
    total++;
    if (trunc_cnt !== 1 || srs !== 0 || lm !== 16'h8000) begin
      bad++; $display("FAIL trunc_send: pulses=%0d sready_seen=%0d lastmask=%h required 1 0 8000", trunc_cnt, srs, lm);
    end
    total++;
    if (got[0] !== 8'hde || got[15] !== 8'h98 || s_ready !== 1'b1) begin
      bad++; $display("FAIL trunc_digest: b0=%h b15=%h sr=%b required de 98 1", got[0], got[15], s_ready);
    end
  endtask

  task automatic test_core_wait();
    int first, pulses, stall, srs;
    logic [0:127] m; logic [7:0] w;
    logic [7:0] got [16]; logic [15:0] lm; bit to;
    core_ready = 1'b0;
    send_msg(abc_b, 3, 1'b1);
    observe_issue(20, first, pulses, m, w);
    total++;
    if (pulses !== 0) begin bad++; $display("FAIL wait_no_issue: pulses=%0d required 0", pulses); end
    core_ready = 1'b1;
    observe_issue(4, first, pulses, m, w);
    total++;
    if (first !== 1 || pulses !== 1 || m !== M_ABC) begin
      bad++; $display("FAIL wait_issue: first=%0d pulses=%0d msg=%h required 1 1 %h", first, pulses, m, M_ABC);
    end
    give_digest(D_ABC);
    collect_digest(4'b1111, 16, got, lm, stall, srs, to);
    total++;
    if (got[0] !== 8'h90 || got[15] !== 8'h72 || to !== 1'b0) begin
      bad++; $display("FAIL wait_digest: b0=%h b15=%h to=%b required 90 72 0", got[0], got[15], to);
    end
  endtask

  task automatic test_backpressure();
    int first, pulses, stall, srs;
    logic [0:127] m; logic [7:0] w;
    logic [7:0] got [16]; logic [15:0] lm; bit to;
    core_ready = 1'b1;
    @(negedge clk);
    core_digest = D_X; core_digest_valid = 1'b1;
    @(negedge clk);
    core_digest_valid = 1'b0; core_digest = '0;
    @(negedge clk);
    total++;
    if (d_valid !== 1'b0 || d_data !== 8'h00 || s_ready !== 1'b1) begin
      bad++; $display("FAIL spurious_digest: dv=%b d=%h sr=%b required 0 00 1", d_valid, d_data, s_ready);
    end
    send_msg(abc_b, 3, 1'b1);
    observe_issue(4, first, pulses, m, w);
    give_digest(D_ABC);
    collect_digest(4'b1001, 16, got, lm, stall, srs, to);
    for (int i = 0; i < 16; i++) begin
      total++;
      if (got[i] !== D_ABC[8*i +: 8]) begin
        bad++; $display("FAIL bp_byte%0d: got %h required %h", i, got[i], D_ABC[8*i +: 8]);
      end
    end
    total++;
    if (stall !== 0 || lm !== 16'h8000 || to !== 1'b0) begin
      bad++; $display("FAIL bp_hold: unstable=%0d lastmask=%h to=%b required 0 8000 0", stall, lm, to);
    end
  endtask

  task automatic test_reset_mid_send();
    int first, pulses, stall, srs;
    logic [0:127] m; logic [7:0] w;
    logic [7:0] got [16]; logic [15:0] lm; bit to;
    core_ready = 1'b1;
    send_msg(abc_b, 3, 1'b1);
    observe_issue(4, first, pulses, m, w);
    give_digest(D_X);
    collect_digest(4'b1111, 7, got, lm, stall, srs, to);
    total++;
    if (d_valid !== 1'b1 || d_data !== D_X[56 +: 8]) begin
      bad++; $display("FAIL mid_byte7: dv=%b d=%h required 1 %h", d_valid, d_data, D_X[56 +: 8]);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({s_ready, core_msg_valid, d_valid, d_last, trunc_err, core_msg_in, core_msg_width, d_data} !== '0) begin
      bad++;
      $display("FAIL mid_reset_values: s_ready=%b mv=%b dv=%b dl=%b te=%b msg=%h w=%h d=%h required all 0",
               s_ready, core_msg_valid, d_valid, d_last, trunc_err, core_msg_in, core_msg_width, d_data);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_abc();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      abc_b[i] = 8'h00;
      seq_b[i] = 8'(i);
    end
    abc_b[0] = 8'h61; abc_b[1] = 8'h62; abc_b[2] = 8'h63;
    test_reset();
    test_abc();
    test_full_last();
    test_truncate();
    test_core_wait();
    test_backpressure();
    test_reset_mid_send();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
